// File: rtl/dvbs2_bch_normal_t12_checker.sv
// DVB-S2 normal-frame t=12 BCH codeword checker: byte-serial division by g(x),
// with a remainder/pass-fail result per codeword and saturating frame statistics.

package dvbs2_bch_normal_t12_pkg;

    // Minimal polynomials g1..g12 of the normal-frame t=12 code, x^16..x^0
    localparam logic [11:0][16:0] MIN_POLYS = {
        17'h11AE3, 17'h13A2D, 17'h175A7, 17'h10EA1,
        17'h17367, 17'h1AF65, 17'h1F7B5, 17'h11F2F,
        17'h15A55, 17'h10FBD, 17'h10173, 17'h1002D
    };

    // g(x) = g1 * ... * g12 over GF(2); x^192 is implicit and dropped
    function automatic logic [191:0] bch_gen_poly();
        logic [192:0] prod;
        logic [192:0] acc;
        prod = 193'd1;
        for (int i = 0; i < 12; i++) begin
            acc = '0;
            for (int t = 0; t < 17; t++) begin
                if (MIN_POLYS[i][t]) acc = acc ^ (prod << t);
            end
            prod = acc;
        end
        return prod[191:0];
    endfunction

endpackage

module dvbs2_bch_normal_t12_checker
    import dvbs2_bch_normal_t12_pkg::*;
#(
    parameter logic [191:0] G_POLY = bch_gen_poly()
) (
    input  logic         clk_1x,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_sop,
    input  logic         in_eop,
    output logic         res_valid,
    output logic [191:0] res_rem,
    output logic         res_err,
    output logic [13:0]  res_len,
    output logic [15:0]  frame_cnt,
    output logic [15:0]  err_cnt,
    output logic [15:0]  abort_cnt
);

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t         state;
    logic [191:0]   rem_acc;
    logic [13:0]    len_acc;

    logic           take;
    logic           restart;
    logic [191:0]   rem_next;
    logic [13:0]    len_next;

    // Eight serial division steps, bit 7 (highest order) first
    function automatic logic [191:0] absorb(input logic [191:0] r, input logic [7:0] b);
        logic [191:0] acc;
        logic         fb;
        acc = r;
        for (int i = 7; i >= 0; i--) begin
            fb  = acc[191];
            acc = {acc[190:0], b[i]} ^ (fb ? G_POLY : 192'd0);
        end
        return acc;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [13:0] sat_inc14(input logic [13:0] v);
        return (v == 14'h3FFF) ? v : v + 14'd1;
    endfunction

    // A byte is absorbed inside a frame or when it starts one; sop always reseeds
    always_comb begin
        restart  = in_sop;
        take     = in_valid && (state == IN_FRAME || in_sop);
        rem_next = absorb(restart ? 192'd0 : rem_acc, in_data);
        len_next = restart ? 14'd1 : sat_inc14(len_acc);
    end

    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem_acc   <= '0;
            len_acc   <= '0;
            res_valid <= 1'b0;
            res_rem   <= '0;
            res_err   <= 1'b0;
            res_len   <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            res_valid <= 1'b0;
            if (take) begin
                rem_acc <= rem_next;
                len_acc <= len_next;
                if (state == IN_FRAME && in_sop) begin
                    abort_cnt <= sat_inc16(abort_cnt);
                end
                if (in_eop) begin
                    state     <= IDLE;
                    res_valid <= 1'b1;
                    res_rem   <= rem_next;
                    res_err   <= |rem_next;
                    res_len   <= len_next;
                    frame_cnt <= sat_inc16(frame_cnt);
                    if (|rem_next) err_cnt <= sat_inc16(err_cnt);
                end else begin
                    state <= IN_FRAME;
                end
            end
        end
    end

endmodule

// File: doc/dvbs2_bch_normal_t12_checker.md
# dvbs2_bch_normal_t12_checker

Receive-side BCH check for DVB-S2 normal frames at t=12. It divides each received BCH codeword (message plus 192 parity bits) by the degree-192 generator g(x), a byte per clock. It reports the 192-bit remainder, a pass/fail flag and running frame/error statistics. It is the checking end of the BCH encoder path, placed after the LDPC decoder output and ahead of BB-frame descrambling.

## Interface
- G_POLY, default: EN 302 307 normal-frame t=12 generator, the product g1…g12, with coefficients x^191..x^0 (x^192 implicit). Meaning: division polynomial.
- clk_1x  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  qualifies in_data, in_sop and in_eop.
- in_data  in  8  codeword byte; bit 7 is the earliest-transmitted (highest-order) bit.
- in_sop  in  1  first byte of a codeword; valid only with in_valid.
- in_eop  in  1  last byte of a codeword; valid only with in_valid.
- res_valid  out  1  one-cycle pulse; the result fields are valid.
- res_rem  out  192  codeword(x) mod g(x); bit 191 is the coefficient of x^191.
- res_err  out  1  1 when res_rem is nonzero.
- res_len  out  14  number of bytes in the checked codeword.
- frame_cnt  out  16  count of completed codewords; saturates at 0xFFFF.
- err_cnt  out  16  count of completed codewords with res_err=1; saturates at 0xFFFF.
- abort_cnt  out  16  count of codewords restarted by an early in_sop; saturates.

## Operation
- The state machine has two states, IDLE and IN_FRAME.
  - IDLE, valid byte with in_sop: the remainder is seeded from 0, the byte is absorbed, len=1, next state IN_FRAME. If in_eop is also set, the frame completes immediately (single-byte frame).
  - IDLE, valid byte without in_sop: the byte is discarded and no counter changes.
  - IN_FRAME, valid byte without in_sop: the byte is absorbed and len increments.
  - IN_FRAME, valid byte with in_eop: the byte is absorbed, the result is emitted, next state IDLE.
  - IN_FRAME, in_sop: abort_cnt increments. The remainder is reseeded from 0 with this byte, len=1, and the state stays IN_FRAME. The aborted frame produces no result.
- Absorbing a byte applies 8 serial division steps, bit 7 first. Each step is r = {r[190:0], b} XOR (old r[191] ? G_POLY : 0). The 8 steps form a single combinational chain and are registered once per byte.
- A codeword is accepted when its remainder is zero. Feeding message then parity, MSB first, yields exactly c(x) mod g(x).
- Length counter:
  - 14 bits, enough for the 8100-byte normal frame.
  - It saturates at 0x3FFF and does not wrap.
  - Length is not checked against the code rate; downstream logic compares res_len.
- Result emission:
  - res_rem, res_err and res_len are registered and held until the next emission.
  - frame_cnt increments once per emission; err_cnt increments in the same cycle when res_err=1.
- in_valid=0 cycles are gaps. All state holds; gaps of any length are allowed anywhere.

## Timing
- Reset (rst_n=0, asynchronous) clears the following; release is synchronous to clk_1x:
  - state = IDLE, r = 0, len = 0;
  - res_valid = 0, res_rem = 0, res_err = 0, res_len = 0;
  - all three counters = 0.
- Throughput is 1 byte per clock with no back-pressure. The block is always ready.
- Latency: res_valid pulses in the cycle after the clock edge that accepted the in_eop byte (1-cycle latency).
- Back-to-back frames: in_sop may arrive in the cycle immediately after in_eop. The result of the first frame is unaffected by the new frame.
- Reset mid-frame discards the partial frame with no result and no counter update.
- Counters that are already saturated do not wrap.

## Test plan
- All-zero codeword of 8100 bytes, sop and eop correct -> one res_valid; res_rem=0, res_err=0, res_len=8100, frame_cnt=1, err_cnt=0.
- 8100 bytes all zero except a last byte of 0x01 -> res_rem=192'h1, res_err=1, err_cnt=1. With a last byte of 0x80 -> res_rem=192'h80.
- Reference-model-encoded random 7032-byte message plus 24 parity bytes -> res_err=0. The same frame with one bit flipped -> res_err=1, and res_rem equals x^k mod g(x) from the model.
- A 100-byte frame, then in_sop again without in_eop, then a clean 50-byte frame -> abort_cnt=1, exactly one res_valid with res_len=50, frame_cnt=1.
- Random in_valid gaps of 0–5 cycles inside frames, plus eop/sop back to back -> results identical to the gap-free run, with res_valid exactly 1 cycle after each eop.
- rst_n pulled low asynchronously mid-frame, then a clean frame -> outputs and counters are 0 during reset, no stale result appears, and the next frame is checked correctly.
